pld_fuse_loader: RTL and testbench
==================================

Name: pld_fuse_loader

Overview:
Serial configuration loader that sits directly upstream of the pld block and drives its AND-matrix and OR-matrix fuse configuration inputs. It accepts a one-bit-per-beat fuse bitstream over a valid/ready handshake and assembles it in shadow registers. It checks an even-parity trailer bit and commits both fuse vectors atomically. The pld never sees a partially loaded configuration.

Parameters:
NUM_PORTS_IN, 1, number of pld inputs N; must be >= 1.
NUM_PORTS_OUT, 1, number of pld outputs M; must be >= 1.
AND_FUSES (localparam), (2**(N+2))*(N**2), AND-matrix fuse count.
OR_FUSES (localparam), M*(2**(2*N)), OR-matrix fuse count.
CNT_W (localparam), $clog2(AND_FUSES+OR_FUSES+1), bit counter width.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin a new load; sampled in IDLE only
abort_i  in  1  discard the load in progress
cfg_data_i  in  1  serial fuse bit
cfg_valid_i  in  1  cfg_data_i valid
cfg_ready_o  out  1  loader accepts a bit this cycle
and_fuses_o  out  AND_FUSES  committed AND fuses; connects to pld and_matrix_fuses_conf_i
or_fuses_o  out  OR_FUSES  committed OR fuses; connects to pld or_matrix_fuses_conf_i
busy_o  out  1  load in progress
done_o  out  1  one-cycle pulse after a successful commit
error_o  out  1  sticky parity error flag

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; counter 0; shadow registers, and_fuses_o, or_fuses_o all 0; cfg_ready_o, busy_o, done_o and error_o all 0.
- Beat rule: a bit is accepted on a rising edge where cfg_valid_i && cfg_ready_o. cfg_data_i is ignored otherwise.
- cfg_ready_o is 1 exactly in LOAD_AND, LOAD_OR and LOAD_PAR, and is a combinational decode of the state. busy_o uses the same decode.
- Bitstream order: AND_FUSES bits first, LSB first, so accepted bit k goes to shadow_and[k]. Then OR_FUSES bits, LSB first. Then one parity bit.
- Parity rule: the parity bit is chosen so that the total number of 1s across all fuse bits plus the parity bit is even. A running XOR accumulator is updated on every accepted bit.
- States and transitions:
  IDLE: start_i=1 -> LOAD_AND; counter, shadows and parity accumulator cleared; error_o cleared.
  LOAD_AND: on each accepted bit, counter increments. On the accept of bit AND_FUSES-1 -> LOAD_OR, counter reset to 0.
  LOAD_OR: same counting. On the accept of bit OR_FUSES-1 -> LOAD_PAR.
  LOAD_PAR: on the accept of the parity bit -> IDLE, with the outcome decided on that same edge:
    - Parity OK: and_fuses_o/or_fuses_o take the full shadow contents on that edge; done_o=1 for the next cycle only.
    - Parity bad: outputs unchanged; error_o=1, held until the next start_i in IDLE.
- abort_i=1 in any LOAD_* state -> IDLE next edge; shadows discarded; outputs unchanged; no done_o, no error_o change. abort_i has priority over a same-cycle accepted beat; that bit is dropped.
- start_i outside IDLE: ignored. abort_i in IDLE: no effect. start_i and abort_i together in IDLE: start wins, since abort only acts in LOAD_*.
- Back-to-back: start_i may be asserted in the cycle done_o is high (state is IDLE); done_o still completes its pulse.
- Throughput: 1 bit per cycle. Minimum load is AND_FUSES+OR_FUSES+1 cycles after leaving IDLE, plus 1 cycle to reach LOAD_AND.
- Outputs are registered and only change at reset or at a successful commit. No output glitches mid-load.

Test Plan:
- N=1, M=1 (AND_FUSES=8, OR_FUSES=4): start, stream AND=8'hA5 LSB-first, OR=4'h3, parity 0, valid always high -> after the parity accept edge and_fuses_o=8'hA5, or_fuses_o=4'h3; done_o high exactly 1 cycle; busy_o low; 14 cycles from start_i to done_o.
- Same stream with parity bit 1 -> error_o=1 and sticky; outputs keep the prior values (0 after reset); no done_o. The next start_i clears error_o.
- Valid throttling: the same good stream with cfg_valid_i toggling 1/0 every cycle -> identical final outputs; the counter advances only on handshakes.
- abort_i asserted after 5 AND bits, with a beat presented the same cycle -> IDLE, cfg_ready_o=0, outputs unchanged. A new full load of AND=8'h0F, OR=4'hF, parity 0 then commits correctly.
- rst_ni pulsed low mid LOAD_OR after a previous commit of 8'hA5/4'h3 -> outputs go to 0 immediately (asynchronous), state IDLE, all flags 0.
- start_i held high during LOAD_AND and in the done_o cycle -> ignored mid-load; accepted from IDLE, with busy_o=1 on the following cycle.

Source files
------------

// File: rtl/pld_fuse_loader.sv
// Serial fuse bitstream loader for the pld: assembles AND/OR fuse vectors in shadow
// registers, checks an even-parity trailer and commits both vectors atomically.
module pld_fuse_loader #(
    parameter  int NUM_PORTS_IN  = 1,
    parameter  int NUM_PORTS_OUT = 1,
    localparam int AND_FUSES     = (2**(NUM_PORTS_IN+2))*(NUM_PORTS_IN**2),
    localparam int OR_FUSES      = NUM_PORTS_OUT*(2**(2*NUM_PORTS_IN)),
    localparam int CNT_W         = $clog2(AND_FUSES+OR_FUSES+1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 cfg_data_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic [AND_FUSES-1:0] and_fuses_o,
    output logic [OR_FUSES-1:0]  or_fuses_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_AND,
        LOAD_OR,
        LOAD_PAR
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [AND_FUSES-1:0] r_shadow_and;
    logic [OR_FUSES-1:0]  r_shadow_or;
    logic [AND_FUSES-1:0] r_and_fuses;
    logic [OR_FUSES-1:0]  r_or_fuses;
    logic                 r_par;
    logic                 r_done;
    logic                 r_error;
    logic                 w_ready;
    logic                 w_beat;
    logic                 w_last_and;
    logic                 w_last_or;
    logic                 w_par_ok;

    // Abort wins over a beat presented in the same cycle, so it never counts as accepted.
    assign w_beat     = cfg_valid_i && w_ready && !abort_i;
    assign w_last_and = (r_cnt == CNT_W'(AND_FUSES-1));
    assign w_last_or  = (r_cnt == CNT_W'(OR_FUSES-1));
    assign w_par_ok   = !(r_par ^ cfg_data_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start_i) w_state_nxt = LOAD_AND;
            LOAD_AND: if (abort_i) w_state_nxt = IDLE;
                      else if (w_beat && w_last_and) w_state_nxt = LOAD_OR;
            LOAD_OR:  if (abort_i) w_state_nxt = IDLE;
                      else if (w_beat && w_last_or) w_state_nxt = LOAD_PAR;
            LOAD_PAR: if (abort_i || w_beat) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state != IDLE);
    end

    // Shadows are filled by shifting in at the MSB, so the first bit lands at index 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_shadow_and <= '0;
            r_shadow_or  <= '0;
            r_and_fuses  <= '0;
            r_or_fuses   <= '0;
            r_par        <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_cnt        <= '0;
                        r_shadow_and <= '0;
                        r_shadow_or  <= '0;
                        r_par        <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                LOAD_AND: begin
                    if (w_beat) begin
                        r_shadow_and <= {cfg_data_i, r_shadow_and[AND_FUSES-1:1]};
                        r_par        <= r_par ^ cfg_data_i;
                        r_cnt        <= w_last_and ? '0 : r_cnt + 1'b1;
                    end
                end
                LOAD_OR: begin
                    if (w_beat) begin
                        r_shadow_or <= {cfg_data_i, r_shadow_or[OR_FUSES-1:1]};
                        r_par       <= r_par ^ cfg_data_i;
                        r_cnt       <= w_last_or ? '0 : r_cnt + 1'b1;
                    end
                end
                LOAD_PAR: begin
                    if (w_beat) begin
                        if (w_par_ok) begin
                            r_and_fuses <= r_shadow_and;
                            r_or_fuses  <= r_shadow_or;
                            r_done      <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_ready_o = w_ready;
    assign busy_o      = w_ready;
    assign and_fuses_o = r_and_fuses;
    assign or_fuses_o  = r_or_fuses;
    assign done_o      = r_done;
    assign error_o     = r_error;

endmodule

// File: tb/tb_pld_fuse_loader.sv
// Scoreboard bench for pld_fuse_loader (N=1, M=1): stimulus queues expected commit/error
// events, a negedge monitor pops and compares them as the DUT raises done_o/error_o.
module tb_pld_fuse_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] and_fuses;
    logic [3:0] or_fuses;
    logic       busy;
    logic       done;
    logic       error;

    typedef struct {
        bit         is_err;
        logic [7:0] exp_and;
        logic [3:0] exp_or;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic err_q = 1'b0;

    pld_fuse_loader #(
        .NUM_PORTS_IN  (1),
        .NUM_PORTS_OUT (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .cfg_data_i  (cfg_data),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .and_fuses_o (and_fuses),
        .or_fuses_o  (or_fuses),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Bit 0 of the stream goes first: AND LSB-first, then OR LSB-first, then parity.
    task automatic send_load(input logic [7:0] a, input logic [3:0] o, input logic p,
                             input bit throttle);
        logic [12:0] bits;
        bits = {p, o, a};
        for (int i = 0; i < 13; i++) begin
            if (throttle) begin
                cfg_valid = 1'b0;
                cfg_data  = ~bits[i];
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = bits[i];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done || (error && !err_q)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, done, error}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_kind", {31'd0, !done}, {31'd0, e.is_err});
                    chk("and_fuses", {24'd0, and_fuses}, {24'd0, e.exp_and});
                    chk("or_fuses", {28'd0, or_fuses}, {28'd0, e.exp_or});
                    if (e.lat != 0) chk("latency_edges", cyc - start_cyc, e.lat);
                end
            end
        end
        err_q <= error;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_data  = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_and", {24'd0, and_fuses}, 32'd0);
        chk("rst_or", {28'd0, or_fuses}, 32'd0);

        // Good load A5/3: 6 ones, parity 0; parity accepted 13 edges after start edge
        exp_q.push_back('{is_err: 1'b0, exp_and: 8'hA5, exp_or: 4'h3, lat: 13});
        do_start();
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ready", {31'd0, cfg_ready}, 32'd1);
        chk("load_outs_held", {20'd0, and_fuses, or_fuses}, 32'd0);
        send_load(8'hA5, 4'h3, 1'b0, 1'b0);
        chk("good_done_hi", {31'd0, done}, 32'd1);
        chk("good_busy_lo", {31'd0, busy}, 32'd0);
        tick();
        chk("good_done_pulse", {31'd0, done}, 32'd0);

        // Bad parity: error sticky, outputs keep A5/3, no done
        exp_q.push_back('{is_err: 1'b1, exp_and: 8'hA5, exp_or: 4'h3, lat: 13});
        do_start();
        send_load(8'hA5, 4'h3, 1'b1, 1'b0);
        chk("bad_error", {31'd0, error}, 32'd1);
        chk("bad_no_done", {31'd0, done}, 32'd0);
        repeat (3) tick();
        chk("bad_error_sticky", {31'd0, error}, 32'd1);
        chk("bad_outs_kept", {20'd0, and_fuses, or_fuses}, {20'd0, 8'hA5, 4'h3});
        do_start();
        chk("start_clears_error", {31'd0, error}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort after 5 AND bits with a beat presented the same cycle
        do_start();
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_ready", {31'd0, cfg_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_outs", {20'd0, and_fuses, or_fuses}, {20'd0, 8'hA5, 4'h3});
        chk("abort_flags", {30'd0, done, error}, 32'd0);
        tick();

        // Fresh load 0F/F: 8 ones, parity 0
        exp_q.push_back('{is_err: 1'b0, exp_and: 8'h0F, exp_or: 4'hF, lat: 13});
        do_start();
        send_load(8'h0F, 4'hF, 1'b0, 1'b0);
        chk("reload_done", {31'd0, done}, 32'd1);
        tick();

        // Throttled A5/3: each bit preceded by an invalid cycle, so 26 edges
        exp_q.push_back('{is_err: 1'b0, exp_and: 8'hA5, exp_or: 4'h3, lat: 26});
        do_start();
        send_load(8'hA5, 4'h3, 1'b0, 1'b1);
        chk("thr_done", {31'd0, done}, 32'd1);
        tick();

        // start held through a 0F/F load and the done cycle
        start = 1'b1;
        tick();
        exp_q.push_back('{is_err: 1'b0, exp_and: 8'h0F, exp_or: 4'hF, lat: 0});
        send_load(8'h0F, 4'hF, 1'b0, 1'b0);
        chk("held_done", {31'd0, done}, 32'd1);
        tick();
        start = 1'b0;
        chk("held_restart_busy", {31'd0, busy}, 32'd1);
        chk("held_done_pulse", {31'd0, done}, 32'd0);

        // Async reset mid LOAD_OR after the 0F/F commit
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_and", {24'd0, and_fuses}, 32'd0);
        chk("arst_or", {28'd0, or_fuses}, 32'd0);
        chk("arst_flags", {28'd0, cfg_ready, busy, done, error}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
